// File: rtl/seq_detect_1011_if.sv
// Serial-bit and status bundle for the 1011 sequence detector.
// The master drives the bit stream; the slave (detector) returns detect/count/state.
interface seq_detect_1011_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             clear_cnt;
  logic             detect;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       state_out;

  modport master (
    output din,
    output din_valid,
    output clear_cnt,
    input  detect,
    input  match_count,
    input  state_out
  );

  modport slave (
    input  din,
    input  din_valid,
    input  clear_cnt,
    output detect,
    output match_count,
    output state_out
  );
endinterface

// File: rtl/seq_detect_1011.sv
// Moore FSM detecting the serial pattern 1011, with a saturating match counter.
// Define SEQ_DETECT_OVERLAP_EN to reuse the trailing '1' of a match (overlapping detection).
module seq_detect_1011 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_1011_if.slave   bus
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Raw bits so the unused encodings 101/110/111 are representable and recoverable.
  logic [2:0]       state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_e'(state_q);
    case (state_q)
      S0: if (bus.din_valid) state_d = bus.din ? S1 : S0;
      S1: if (bus.din_valid) state_d = bus.din ? S1 : S2;
      S2: if (bus.din_valid) state_d = bus.din ? S3 : S0;
      S3: if (bus.din_valid) state_d = bus.din ? S4 : S2;
`ifdef SEQ_DETECT_OVERLAP_EN
      S4: if (bus.din_valid) state_d = bus.din ? S1 : S2;
`else
      S4: if (bus.din_valid) state_d = bus.din ? S1 : S0;
`endif
      default: state_d = S0;
    endcase
  end

  // Clear wins over a same-cycle increment; saturation happens inside sat_inc.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear_cnt) begin
      cnt_d = '0;
    end else if (bus.din_valid && (state_d == S4)) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  assign bus.detect      = (state_q == S4);
  assign bus.match_count = cnt_q;
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed self-checking bench for seq_detect_1011 (8-bit and 2-bit counter instances).
module tb_seq_detect_1011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8;
  logic rst2;

  seq_detect_1011_if #(.CNT_W(8)) if8 ();
  seq_detect_1011_if #(.CNT_W(2)) if2 ();

  seq_detect_1011 #(.CNT_W(8)) u8 (.clk(clk), .reset(rst8), .bus(if8.slave));
  seq_detect_1011 #(.CNT_W(2)) u2 (.clk(clk), .reset(rst2), .bus(if2.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv8(input logic r, input logic d, input logic v, input logic c);
    rst8 = r; if8.din = d; if8.din_valid = v; if8.clear_cnt = c;
    @(posedge clk); #1;
  endtask

  task automatic drv2(input logic r, input logic d, input logic v, input logic c);
    rst2 = r; if2.din = d; if2.din_valid = v; if2.clear_cnt = c;
    @(posedge clk); #1;
  endtask

  int bits[7];
  int exp_st[7];
  int exp_cnt[7];
  int pat[4];

  initial begin
    bits = '{1, 0, 1, 1, 0, 1, 1};
    pat  = '{1, 0, 1, 1};
`ifdef SEQ_DETECT_OVERLAP_EN
    exp_st  = '{1, 2, 3, 4, 2, 3, 4};
    exp_cnt = '{0, 0, 0, 1, 1, 1, 2};
`else
    exp_st  = '{1, 2, 3, 4, 0, 1, 1};
    exp_cnt = '{0, 0, 0, 1, 1, 1, 1};
`endif
    rst2 = 1'b1; if2.din = 1'b0; if2.din_valid = 1'b0; if2.clear_cnt = 1'b0;

    // Reset overrides a valid '1' and a clear request.
    drv8(1, 1, 1, 1);
    check("rst_state", if8.state_out, 0);
    check("rst_detect", if8.detect, 0);
    check("rst_count", if8.match_count, 0);

    // Stream 1,0,1,1,0,1,1
    for (int i = 0; i < 7; i++) begin
      drv8(0, bits[i][0], 1, 0);
      check($sformatf("stream_state%0d", i), if8.state_out, exp_st[i]);
      check($sformatf("stream_detect%0d", i), if8.detect, (exp_st[i] == 4) ? 1 : 0);
      check($sformatf("stream_count%0d", i), if8.match_count, exp_cnt[i]);
    end

    // Gapped stream: state, detect and count hold while din_valid is low.
    drv8(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drv8(0, pat[i][0], 1, 0);
      check($sformatf("gap_bit_state%0d", i), if8.state_out, i + 1);
      drv8(0, ~pat[i][0], 0, 0);
      check($sformatf("gap_hold_state%0d", i), if8.state_out, i + 1);
    end
    check("gap_detect", if8.detect, 1);
    check("gap_count", if8.match_count, 1);

    // Clear from S4 on a valid '0': count cleared, FSM advances normally.
    drv8(0, 0, 1, 1);
    check("clr_count", if8.match_count, 0);
`ifdef SEQ_DETECT_OVERLAP_EN
    check("clr_state", if8.state_out, 2);
`else
    check("clr_state", if8.state_out, 0);
`endif

    // Mid-sequence reset discards the "101" prefix.
    drv8(1, 0, 0, 0);
    drv8(0, 1, 1, 0);
    drv8(0, 0, 1, 0);
    drv8(0, 1, 1, 0);
    check("pre_rst_state", if8.state_out, 3);
    drv8(1, 1, 1, 0);
    check("mid_rst_state", if8.state_out, 0);
    drv8(0, 1, 1, 0);
    check("post_rst_state", if8.state_out, 1);
    check("post_rst_detect", if8.detect, 0);
    check("post_rst_count", if8.match_count, 0);

    // 2-bit counter: saturation at 3, then clear beating a fifth match.
    drv2(1, 0, 0, 0);
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) drv2(0, pat[i][0], 1, 0);
      check($sformatf("sat_detect%0d", m), if2.detect, 1);
      check($sformatf("sat_count%0d", m), if2.match_count, (m < 3) ? m + 1 : 3);
    end
    drv2(0, 1, 1, 0);
    drv2(0, 0, 1, 0);
    drv2(0, 1, 1, 0);
    check("sat_hold_count", if2.match_count, 3);
    drv2(0, 1, 1, 1);
    check("clr5_count", if2.match_count, 0);
    check("clr5_detect", if2.detect, 1);
    check("clr5_state", if2.state_out, 4);

    // Illegal encoding 110 returns to S0 on the next edge even with din_valid low.
    drv8(1, 0, 0, 0);
    drv8(0, 0, 0, 0);
    force u8.state_q = 3'b110;
    #1;
    check("illegal_detect", if8.detect, 0);
    check("illegal_next", u8.state_d, 0);
    release u8.state_q;
    @(posedge clk); #1;
    check("illegal_recover", if8.state_out, 0);
    check("illegal_recover_det", if8.detect, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
